// File: rtl/om_screen_renderer.sv
// rtl/om_screen_renderer.sv - VGA timing, om-to-tile-cache copy in vblank, and tile renderer
module om_screen_renderer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int TILE_SHIFT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_state,
    output logic        next_screen,
    output logic [6:0]  address_read_om,
    input  logic [10:0] data_read_om,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        busy
);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] GRID_PX  = 10'(10 << TILE_SHIFT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_COPY = 2'd2;

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [1:0]  state_q, state_d;
    logic        pending_q, pending_d;
    logic [6:0]  k_q, k_d;
    logic [2:0]  cache_q [0:99];
    logic [2:0]  cache_d [0:99];
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic [11:0] rgb_q, rgb_d;
    logic        vbs, pend_any, in_grid;
    logic [6:0]  tile_idx;
    logic [2:0]  tile;
    logic        unused_om_bits;

    assign unused_om_bits  = ^data_read_om[7:0];
    assign busy            = (state_q == S_COPY);
    assign address_read_om = (state_q == S_COPY && k_q < 7'd100) ? k_q : 7'd0;
    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign rgb             = rgb_q;

    always_comb begin
        h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end
        vbs         = (h_q == 10'd0) && (v_q == V_VIS);
        pend_any    = pending_q | new_state;
        state_d     = state_q;
        k_d         = k_q;
        pending_d   = pend_any;
        next_screen = 1'b0;
        cache_d     = cache_q;
        case (state_q)
            S_IDLE: begin
                if (vbs && pend_any) begin
                    state_d   = S_COPY;
                    k_d       = 7'd0;
                    pending_d = 1'b0;
                end else if (vbs) begin
                    next_screen = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pend_any && v_q >= V_VIS) begin
                    state_d   = S_COPY;
                    k_d       = 7'd0;
                    pending_d = 1'b0;
                end
            end
            S_COPY: begin
                // om read data lags its address by one cycle, so cycle k lands entry k-1
                if (k_q != 7'd0) begin
                    cache_d[k_q - 7'd1] = data_read_om[10:8];
                end
                if (k_q == 7'd100) begin
                    state_d = S_IDLE;
                end else begin
                    k_d = k_q + 7'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_grid  = (h_q < GRID_PX) && (v_q < GRID_PX) && (h_q < H_VIS) && (v_q < V_VIS);
        tile_idx = in_grid ? (7'(v_q >> TILE_SHIFT) * 7'd10 + 7'(h_q >> TILE_SHIFT)) : 7'd0;
        tile     = cache_q[tile_idx];
        hsync_d  = !((h_q >= HS_START) && (h_q < HS_END));
        vsync_d  = !((v_q >= VS_START) && (v_q < VS_END));
        case (tile)
            3'd0:    rgb_d = 12'h000;
            3'd1:    rgb_d = 12'hFF0;
            3'd2:    rgb_d = 12'h888;
            3'd3:    rgb_d = 12'h00F;
            3'd4:    rgb_d = 12'h0FF;
            3'd5:    rgb_d = 12'hA50;
            3'd6:    rgb_d = 12'h0F0;
            default: rgb_d = 12'hF0F;
        endcase
        if (!in_grid) begin
            rgb_d = 12'h000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= 10'd0;
            v_q       <= 10'd0;
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            k_q       <= 7'd0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            rgb_q     <= 12'h000;
            for (int i = 0; i < 100; i++) begin
                cache_q[i] <= 3'd0;
            end
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            state_q   <= state_d;
            pending_q <= pending_d;
            k_q       <= k_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            rgb_q     <= rgb_d;
            cache_q   <= cache_d;
        end
    end
endmodule

// File: tb/tb_om_screen_renderer.sv
// tb/tb_om_screen_renderer.sv - directed bench for om_screen_renderer on a shrunken raster
module tb_om_screen_renderer;
    localparam int HA = 48, HF = 4, HS = 8, HB = 4;
    localparam int VA = 44, VF = 2, VS = 2, VB = 4;
    localparam int TS = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_state = 1'b0;
    logic        next_screen;
    logic [6:0]  address_read_om;
    logic [10:0] data_read_om = 11'd0;
    logic        hsync, vsync, busy;
    logic [11:0] rgb;
    logic [10:0] om [0:127];

    int checks = 0;
    int errors = 0;
    int tcyc = 0;
    int addr_bad = 0;
    int ns_busy = 0;

    om_screen_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .TILE_SHIFT(TS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .new_state(new_state), .next_screen(next_screen),
        .address_read_om(address_read_om), .data_read_om(data_read_om),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcyc <= 0;
        else        tcyc <= tcyc + 1;
    end

    always @(posedge clk) data_read_om <= om[address_read_om];

    always @(negedge clk) begin
        if (rst_n) begin
            if (address_read_om > 7'd99) addr_bad++;
            if (next_screen && busy) ns_busy++;
        end
    end

    function automatic int hpos();
        return tcyc % HT;
    endfunction

    function automatic int vpos();
        return (tcyc / HT) % VT;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_pos(input string tag, input int x, input int y);
        int n;
        n = 0;
        while (!(hpos() == x && vpos() == y) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        if (n >= 2 * FRAME) check({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_pixel(input string tag, input int x, input int y, input logic [11:0] exp);
        wait_pos(tag, x + 1, y);
        check(tag, {20'd0, rgb}, {20'd0, exp});
    endtask

    initial begin
        int ns_cnt, ns_h, ns_v, hs_low, vs_low, rgb_nz, bcnt, seq_bad, n;
        for (int i = 0; i < 128; i++) om[i] = 11'd0;

        // reset state
        repeat (3) tick();
        check("rst next_screen", {31'd0, next_screen}, 32'd0);
        check("rst addr", {25'd0, address_read_om}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst hsync", {31'd0, hsync}, 32'd1);
        check("rst vsync", {31'd0, vsync}, 32'd1);
        check("rst rgb", {20'd0, rgb}, 32'd0);
        rst_n = 1'b1;

        // frame without new_state: one next_screen at VBS, sync widths, black grid
        ns_cnt = 0; ns_h = -1; ns_v = -1; hs_low = 0; vs_low = 0; rgb_nz = 0;
        repeat (FRAME) begin
            tick();
            if (next_screen) begin ns_cnt++; ns_h = hpos(); ns_v = vpos(); end
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (rgb != 12'h000) rgb_nz++;
        end
        check("t1 ns count", ns_cnt, 1);
        check("t1 ns h", ns_h, 0);
        check("t1 ns v", ns_v, VA);
        check("t1 hsync low", hs_low, HS * VT);
        check("t1 vsync low", vs_low, VS * HT);
        check("t1 rgb nonzero", rgb_nz, 0);
        ns_cnt = 0;
        repeat (FRAME) begin
            tick();
            if (next_screen) ns_cnt++;
        end
        check("t1 no 2nd ns", ns_cnt, 0);

        // new_state 5 cycles into blanking: ordered copy, then new tiles drawn
        om[0] = 11'(2 << 8);
        om[11] = 11'(5 << 8);
        wait_pos("t2 vbs", 0, VA);
        repeat (5) tick();
        new_state = 1'b1;
        tick();
        new_state = 1'b0;
        check("t2 busy start", {31'd0, busy}, 32'd1);
        bcnt = 0; seq_bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy) begin
                if (address_read_om != ((bcnt < 100) ? 7'(bcnt) : 7'd0)) seq_bad++;
                bcnt++;
            end
            tick();
        end
        check("t2 busy cycles", bcnt, 101);
        check("t2 addr order", seq_bad, 0);
        check_pixel("t2 px 0,0", 0, 0, 12'h888);
        check_pixel("t2 px 8,0", 8, 0, 12'h000);
        check_pixel("t2 px 45,2", 45, 2, 12'h000);
        check_pixel("t2 px 5,5", 5, 5, 12'hA50);

        // new_state in active area: cache untouched until next VBS
        om[0] = 11'(3 << 8);
        om[50] = 11'(6 << 8);
        wait_pos("t3 v10", 5, 10);
        new_state = 1'b1;
        tick();
        new_state = 1'b0;
        check_pixel("t3 px 0,20 old", 0, 20, 12'h000);
        wait_pos("t3 vbs", 0, VA);
        check("t3 vbs busy", {31'd0, busy}, 32'd0);
        check("t3 vbs no ns", {31'd0, next_screen}, 32'd0);
        tick();
        check("t3 copy at vbs", {31'd0, busy}, 32'd1);
        check_pixel("t3 px 0,0 new", 0, 0, 12'h00F);
        check_pixel("t3 px 0,20 new", 0, 20, 12'h0F0);

        // new_state coincident with VBS while IDLE
        om[99] = 11'(7 << 8);
        wait_pos("t4 vbs", 0, VA);
        new_state = 1'b1;
        #1;
        check("t4 no ns at vbs", {31'd0, next_screen}, 32'd0);
        check("t4 idle at vbs", {31'd0, busy}, 32'd0);
        tick();
        new_state = 1'b0;
        check("t4 copy start", {31'd0, busy}, 32'd1);
        ns_cnt = 0;
        repeat (200) begin
            tick();
            if (next_screen) ns_cnt++;
        end
        check("t4 ns after copy", ns_cnt, 0);
        check_pixel("t4 px 35,36", 35, 36, 12'h000);
        check_pixel("t4 px 36,36", 36, 36, 12'hF0F);
        check_pixel("t4 px 39,39", 39, 39, 12'hF0F);

        // reset in the middle of a copy
        wait_pos("t6 vbs", 0, VA);
        check("t6 ns at vbs", {31'd0, next_screen}, 32'd1);
        repeat (3) tick();
        new_state = 1'b1;
        tick();
        new_state = 1'b0;
        bcnt = 0;
        while (busy && bcnt < 50) begin
            tick();
            bcnt++;
        end
        check("t6 k50 addr", {25'd0, address_read_om}, 32'd50);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 rst busy", {31'd0, busy}, 32'd0);
        check("t6 rst addr", {25'd0, address_read_om}, 32'd0);
        check("t6 rst hsync", {31'd0, hsync}, 32'd1);
        check("t6 rst vsync", {31'd0, vsync}, 32'd1);
        check("t6 rst rgb", {20'd0, rgb}, 32'd0);
        check("t6 rst ns", {31'd0, next_screen}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        check_pixel("t6 cache 0,0", 0, 0, 12'h000);
        check_pixel("t6 cache 36,36", 36, 36, 12'h000);
        n = 0;
        while (!next_screen && n < 2 * FRAME) begin
            tick();
            n++;
        end
        check("t6 ns seen", {31'd0, next_screen}, 32'd1);
        check("t6 ns h", hpos(), 0);
        check("t6 ns v", vpos(), VA);

        check("addr <= 99", addr_bad, 0);
        check("no ns while busy", ns_busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
